bcd_countdown_timer: RTL and testbench
======================================

// Module: bcd_countdown_timer
// PURPOSE
//   Consumes the 4-digit BCD MM:SS value produced by the time-set button logic and counts it down once per second.
//   Sits between the time-set path and the 7-segment display/alarm logic.
//   Drives the displayed time and signals expiry when the count reaches 00:00.
// PARAMETERS
//   TICK_DIV   50_000_000   clk cycles per 1 s tick (>=2)
//   CNT_W      26           prescaler width, must satisfy 2**CNT_W >= TICK_DIV
// PORTS
//   clk            in   1   system clock, all logic on posedge
//   reset          in   1   synchronous, active-high reset
//   load           in   1   1-cycle pulse: capture set_bin, enter IDLE
//   set_bin        in   16  BCD time: [3:0] sec units, [7:4] sec tens, [11:8] min units, [15:12] min tens
//   start          in   1   level/pulse: begin or resume counting
//   pause          in   1   level/pulse: suspend counting
//   time_bcd       out  16  current BCD MM:SS value, same digit layout as set_bin
//   running        out  1   high while state == RUN
//   expired        out  1   high while state == EXPIRED
//   expired_pulse  out  1   single-cycle strobe on entry to EXPIRED
// BEHAVIOUR
// - Reset (sampled on posedge clk, highest priority):
//   - state=IDLE, time_bcd=16'h0000, prescaler=0;
//   - running=0, expired=0, expired_pulse=0.
// - Load, in any state:
//   - next cycle time_bcd = set_bin; state=IDLE; prescaler=0.
//   - Digits >9 clamp to 9; sec tens >5 clamps to 5.
//   - load beats start/pause in the same cycle.
// - States and transitions (priority: reset > load > pause > start):
//   - IDLE: start & time_bcd!=0 -> RUN. start with time_bcd==0 is ignored.
//   - RUN: pause -> PAUSED. Reaching 00:00 -> EXPIRED. start is ignored.
//   - PAUSED: start & !pause -> RUN. The prescaler holds its value, so a partial second is kept.
//   - EXPIRED: holds 00:00 until load or reset; start and pause are ignored.
//   - start and pause together: pause wins, from both RUN and PAUSED.
// - Prescaler:
//   - counts only in RUN, 0..TICK_DIV-1, then wraps to 0.
//   - tick = (state==RUN) & (prescaler==TICK_DIV-1).
//   - First tick after IDLE->RUN occurs TICK_DIV cycles after the start cycle.
// - Decrement: on tick, time_bcd updates on the next posedge (1-cycle latency). BCD borrow chain:
//   - sec units: 0->9 with borrow, else -1;
//   - sec tens: on borrow, 0->5 with borrow, else -1;
//   - min units: on borrow, 0->9 with borrow, else -1;
//   - min tens: on borrow, -1 (never underflows, because zero is caught first).
// - Expiry:
//   - the decrement that yields 16'h0000 also moves state to EXPIRED in the same update edge;
//   - expired_pulse=1 for exactly that following cycle; expired stays high in EXPIRED.
// - Outputs are registered; running and expired decode the state register and never glitch.
// - Reset mid-count discards the time. Load mid-count replaces the time and stops counting.
// TESTING (TICK_DIV=4)
// - reset, load set_bin=16'h0012, start 1 cycle -> time_bcd goes 0011 then 0010 at 4-cycle spacing.
//   At 0000: expired_pulse 1 cycle, expired=1, running=0.
// - load 16'h1000, start -> after the first tick time_bcd=16'h0959 (borrow through every digit).
// - load 16'h0105, start, pause after 2 cycles, hold 10 cycles, start -> no change while PAUSED.
//   Next decrement lands 2 cycles after resume (prescaler kept).
// - load 16'h0000 then start -> stays IDLE, running=0, no expired_pulse.
// - load 16'h9F7A -> time_bcd=16'h9959 (clamping). Assert load+start together -> IDLE, loaded value.
// - mid-RUN reset -> next cycle time_bcd=0000 and all flags 0.
//   In EXPIRED, start/pause are ignored and load 16'h0003 returns to IDLE.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer: loads a clamped BCD time and counts it down once per
// prescaled second, flagging expiry when the count reaches 00:00.
module bcd_countdown_timer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] set_bin,
    input  logic        start,
    input  logic        pause,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        expired,
    output logic        expired_pulse
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICK_DIV - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] presc, presc_nxt;
    logic [15:0]      time_nxt, dec_val, load_val;
    logic             pulse_nxt, tick;

    function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // One-second BCD decrement with borrow; never called on 00:00.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (t[7:4] != 4'd0) begin
                r[7:4] = t[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (t[11:8] != 4'd0) begin
                    r[11:8] = t[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = t[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign load_val = {clamp(set_bin[15:12], 4'd9), clamp(set_bin[11:8], 4'd9),
                       clamp(set_bin[7:4], 4'd5), clamp(set_bin[3:0], 4'd9)};
    assign dec_val  = bcd_dec(time_bcd);
    assign tick     = (state == RUN) && (presc == PRESC_MAX);

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        time_nxt  = time_bcd;
        pulse_nxt = 1'b0;
        if (load) begin
            state_nxt = IDLE;
            presc_nxt = '0;
            time_nxt  = load_val;
        end else begin
            case (state)
                IDLE: begin
                    if (start && time_bcd != 16'h0000) state_nxt = RUN;
                end
                RUN: begin
                    presc_nxt = tick ? '0 : presc + 1'b1;
                    if (tick) time_nxt = dec_val;
                    // Reaching zero wins over a coincident pause so PAUSED never holds 00:00.
                    if (tick && dec_val == 16'h0000) begin
                        state_nxt = EXPIRED;
                        pulse_nxt = 1'b1;
                    end else if (pause) begin
                        state_nxt = PAUSED;
                    end
                end
                PAUSED: begin
                    if (start && !pause) state_nxt = RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            presc         <= '0;
            time_bcd      <= 16'h0000;
            expired_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            presc         <= presc_nxt;
            time_bcd      <= time_nxt;
            expired_pulse <= pulse_nxt;
        end
    end

    assign running = (state == RUN);
    assign expired = (state == EXPIRED);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: directed scenarios plus random stimulus
// compared against a seconds-based reference model.
module tb_bcd_countdown_timer;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [15:0] set_bin = 16'h0000;
    logic [15:0] time_bcd;
    logic        running, expired, expired_pulse;

    int checks = 0;
    int errors = 0;

    // reference model: mode 0 idle, 1 counting, 2 paused, 3 expired; time kept in seconds
    int m_mode = 0, m_secs = 0, m_pre = 0;
    bit m_pulse = 1'b0;

    bcd_countdown_timer #(.TICK_DIV(TD), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .load(load), .set_bin(set_bin), .start(start),
        .pause(pause), .time_bcd(time_bcd), .running(running), .expired(expired),
        .expired_pulse(expired_pulse)
    );

    always #5 clk = ~clk;

    function automatic int lim(input int d, input int l);
        return (d > l) ? l : d;
    endfunction

    function automatic int set_to_secs(input logic [15:0] b);
        int mt, mu, st, su;
        mt = lim(int'(b[15:12]), 9);
        mu = lim(int'(b[11:8]), 9);
        st = lim(int'(b[7:4]), 5);
        su = lim(int'(b[3:0]), 9);
        return (mt * 10 + mu) * 60 + st * 10 + su;
    endfunction

    function automatic logic [15:0] secs_to_bcd(input int s);
        int m, ss;
        m  = s / 60;
        ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_step();
        bit tk;
        if (reset) begin
            m_mode = 0; m_secs = 0; m_pre = 0; m_pulse = 0;
        end else if (load) begin
            m_mode = 0; m_secs = set_to_secs(set_bin); m_pre = 0; m_pulse = 0;
        end else begin
            m_pulse = 0;
            case (m_mode)
                0: if (start && m_secs != 0) m_mode = 1;
                1: begin
                    tk = (m_pre == TD - 1);
                    m_pre = tk ? 0 : m_pre + 1;
                    if (tk) begin
                        m_secs = m_secs - 1;
                        if (m_secs == 0) begin
                            m_mode = 3;
                            m_pulse = 1;
                        end
                    end
                    if (m_mode == 1 && pause) m_mode = 2;
                end
                2: if (start && !pause) m_mode = 1;
                default: ;
            endcase
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; load = 0; start = 0; pause = 0;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1; set_bin = v;
        cyc();
        load = 0;
    endtask

    task automatic do_start();
        start = 1;
        cyc();
        start = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        cyc();
        cyc();
        reset = 0;
        checks++;
        if (time_bcd !== 16'h0000 || running !== 1'b0 || expired !== 1'b0 || expired_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset: got time=%h run=%b exp=%b pulse=%b, want 0000/0/0/0",
                     time_bcd, running, expired, expired_pulse);
        end
    endtask

    task automatic test_count_expire();
        int n;
        do_load(16'h0012);
        checks++;
        if (time_bcd !== 16'h0012 || running !== 1'b0) begin
            errors++;
            $display("FAIL load_0012: got time=%h run=%b, want 0012/0", time_bcd, running);
        end
        do_start();
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL start_run: got running=%b, want 1", running);
        end
        repeat (3) cyc();
        checks++;
        if (time_bcd !== 16'h0012) begin
            errors++;
            $display("FAIL first_tick_early: got %h, want 0012", time_bcd);
        end
        cyc();
        checks++;
        if (time_bcd !== 16'h0011) begin
            errors++;
            $display("FAIL first_dec: got %h, want 0011", time_bcd);
        end
        repeat (TD) cyc();
        checks++;
        if (time_bcd !== 16'h0010) begin
            errors++;
            $display("FAIL second_dec: got %h, want 0010", time_bcd);
        end
        n = 0;
        while (time_bcd !== 16'h0000 && n < 100) begin
            cyc();
            n++;
        end
        checks++;
        if (n != 10 * TD) begin
            errors++;
            $display("FAIL expire_time: got %0d cycles, want %0d", n, 10 * TD);
        end
        checks++;
        if (expired_pulse !== 1'b1 || expired !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL expire_flags: got pulse=%b exp=%b run=%b, want 1/1/0",
                     expired_pulse, expired, running);
        end
        cyc();
        checks++;
        if (expired_pulse !== 1'b0 || expired !== 1'b1) begin
            errors++;
            $display("FAIL pulse_width: got pulse=%b exp=%b, want 0/1", expired_pulse, expired);
        end
        start = 1; pause = 1;
        repeat (3) cyc();
        start = 0; pause = 0;
        checks++;
        if (expired !== 1'b1 || running !== 1'b0 || time_bcd !== 16'h0000 || expired_pulse !== 1'b0) begin
            errors++;
            $display("FAIL expired_hold: got exp=%b run=%b time=%h pulse=%b, want 1/0/0000/0",
                     expired, running, time_bcd, expired_pulse);
        end
        do_load(16'h0003);
        checks++;
        if (expired !== 1'b0 || running !== 1'b0 || time_bcd !== 16'h0003) begin
            errors++;
            $display("FAIL expired_reload: got exp=%b run=%b time=%h, want 0/0/0003",
                     expired, running, time_bcd);
        end
    endtask

    task automatic test_borrow();
        do_load(16'h1000);
        do_start();
        repeat (TD) cyc();
        checks++;
        if (time_bcd !== 16'h0959) begin
            errors++;
            $display("FAIL borrow_chain: got %h, want 0959", time_bcd);
        end
    endtask

    task automatic test_pause();
        bit bad;
        do_load(16'h0105);
        do_start();
        cyc();
        pause = 1;
        bad = 0;
        repeat (10) begin
            cyc();
            if (time_bcd !== 16'h0105 || running !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL pause_hold: got time=%h run=%b, want 0105/0", time_bcd, running);
        end
        pause = 0;
        do_start();
        cyc();
        checks++;
        if (time_bcd !== 16'h0105 || running !== 1'b1) begin
            errors++;
            $display("FAIL resume_early: got time=%h run=%b, want 0105/1", time_bcd, running);
        end
        cyc();
        checks++;
        if (time_bcd !== 16'h0104) begin
            errors++;
            $display("FAIL resume_partial: got %h, want 0104", time_bcd);
        end
        start = 1; pause = 1;
        cyc();
        start = 0; pause = 0;
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL pause_beats_start: got running=%b, want 0", running);
        end
    endtask

    task automatic test_zero_load();
        bit bad;
        do_load(16'h0000);
        start = 1;
        bad = 0;
        repeat (6) begin
            cyc();
            if (running !== 1'b0 || expired_pulse !== 1'b0 || expired !== 1'b0) bad = 1;
        end
        start = 0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL zero_start: got run=%b pulse=%b exp=%b, want 0/0/0",
                     running, expired_pulse, expired);
        end
    endtask

    task automatic test_clamp_and_priority();
        do_load(16'h9F7A);
        checks++;
        if (time_bcd !== 16'h9959) begin
            errors++;
            $display("FAIL clamp: got %h, want 9959", time_bcd);
        end
        do_start();
        cyc();
        load = 1; start = 1; set_bin = 16'h0200;
        cyc();
        load = 0; start = 0;
        checks++;
        if (time_bcd !== 16'h0200 || running !== 1'b0) begin
            errors++;
            $display("FAIL load_beats_start: got time=%h run=%b, want 0200/0", time_bcd, running);
        end
    endtask

    task automatic test_mid_reset();
        do_load(16'h0230);
        do_start();
        repeat (6) cyc();
        reset = 1;
        cyc();
        reset = 0;
        checks++;
        if (time_bcd !== 16'h0000 || running !== 1'b0 || expired !== 1'b0 || expired_pulse !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got time=%h run=%b exp=%b pulse=%b, want 0000/0/0/0",
                     time_bcd, running, expired, expired_pulse);
        end
    endtask

    task automatic test_random();
        logic [15:0] r;
        int bad;
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            r = 16'($urandom);
            reset = ($urandom_range(0, 399) == 0);
            load  = ($urandom_range(0, 59) == 0);
            set_bin = ($urandom_range(0, 3) == 0) ? r : {8'h00, 4'($urandom_range(0, 1)), r[3:0]};
            start = ($urandom_range(0, 3) == 0);
            pause = ($urandom_range(0, 9) == 0);
            cyc();
            checks++;
            if (time_bcd !== secs_to_bcd(m_secs) || running !== (m_mode == 1) ||
                expired !== (m_mode == 3) || expired_pulse !== m_pulse) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random[%0d]: got time=%h run=%b exp=%b pulse=%b, want %h/%b/%b/%b",
                             i, time_bcd, running, expired, expired_pulse, secs_to_bcd(m_secs),
                             m_mode == 1, m_mode == 3, m_pulse);
                bad++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_count_expire();
        test_borrow();
        test_pause();
        test_zero_load();
        test_clamp_and_priority();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
